sdcard_dma_arbiter: RTL and testbench

Round-robin scheduler that shares the single SD card DMA engine between NUM_REQ requesters: RX data path, TX data path and descriptor fetch. It latches one requester's descriptor (address, length, direction) and issues a one-cycle start to the engine. It then waits for engine done or error, or a timeout, and returns a per-requester completion pulse. New grants are gated by enable, security lock, access grant and power state.

---
 rtl/sdcard_dma_pkg.sv | 13 +
 rtl/sdcard_rr_picker.sv | 27 ++
 rtl/sdcard_dma_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdcard_dma_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdcard_dma_pkg.sv
// rtl/sdcard_dma_pkg.sv - shared types and constants for the SD card DMA arbiter
package sdcard_dma_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_t;

  localparam logic [1:0] PWR_ACTIVE = 2'b00;

endpackage

// File: rtl/sdcard_rr_picker.sv
// rtl/sdcard_rr_picker.sv - combinational round-robin picker, search starts just after last_i
module sdcard_rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  int cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_i) + k) % NUM_REQ;
      if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sdcard_dma_arbiter.sv
// rtl/sdcard_dma_arbiter.sv - round-robin sharing of one SD card DMA engine between requesters
module sdcard_dma_arbiter
  import sdcard_dma_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      PCLK_i,
  input  logic                      PRESETn_i,
  input  logic                      arb_enable_i,
  input  logic                      security_lock_i,
  input  logic                      access_granted_i,
  input  logic [1:0]                power_state_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        req_done_o,
  output logic [NUM_REQ-1:0]        req_error_o,
  output logic                      eng_start_o,
  output logic [ADDR_W-1:0]         eng_addr_o,
  output logic [LEN_W-1:0]          eng_len_o,
  output logic                      eng_we_o,
  input  logic                      eng_done_i,
  input  logic                      eng_error_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                      arb_busy_o,
  output logic                      timeout_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    last_q, last_d, id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                we_q, we_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  ready_q, ready_d, done_q, done_d, error_q, error_d;
  logic                start_q, start_d, timeout_q, timeout_d;

  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [LEN_W-1:0]    len_arr  [NUM_REQ];
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic                grant_ok;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    assign len_arr[g]  = req_len_i[g*LEN_W +: LEN_W];
  end

  sdcard_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req_i   (req_valid_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign grant_ok = arb_enable_i & ~security_lock_i & access_granted_i &
                    (power_state_i == PWR_ACTIVE);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    ready_d   = '0;
    done_d    = '0;
    error_d   = '0;
    start_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_ok && pick_valid) begin
          id_d             = pick_idx;
          last_d           = pick_idx;
          addr_d           = addr_arr[pick_idx];
          len_d            = len_arr[pick_idx];
          we_d             = req_we_i[pick_idx];
          ready_d[pick_idx] = 1'b1;
          state_d          = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // A zero-length descriptor is rejected without ever touching the engine.
        if (len_q == '0) begin
          error_d[id_q] = 1'b1;
          state_d       = ARB_RELEASE;
        end else begin
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (eng_error_i) begin
          error_d[id_q] = 1'b1;
          state_d       = ARB_RELEASE;
        end else if (eng_done_i) begin
          done_d[id_q] = 1'b1;
          state_d      = ARB_RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          error_d[id_q] = 1'b1;
          timeout_d     = 1'b1;
          state_d       = ARB_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
    if (!PRESETn_i) begin
      state_q   <= ARB_IDLE;
      last_q    <= IDX_W'(NUM_REQ - 1);
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= '0;
      done_q    <= '0;
      error_q   <= '0;
      start_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      error_q   <= error_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
    end
  end

  assign req_ready_o = ready_q;
  assign req_done_o  = done_q;
  assign req_error_o = error_q;
  assign eng_start_o = start_q;
  assign eng_addr_o  = addr_q;
  assign eng_len_o   = len_q;
  assign eng_we_o    = we_q;
  assign grant_id_o  = id_q;
  assign arb_busy_o  = (state_q != ARB_IDLE);
  assign timeout_o   = timeout_q;

  a_ready_oh: assert property (@(posedge PCLK_i) disable iff (!PRESETn_i) $onehot0(req_ready_o));
  a_done_oh:  assert property (@(posedge PCLK_i) disable iff (!PRESETn_i) $onehot0(req_done_o));
  a_err_oh:   assert property (@(posedge PCLK_i) disable iff (!PRESETn_i) $onehot0(req_error_o));
  a_excl:     assert property (@(posedge PCLK_i) disable iff (!PRESETn_i) !(|req_done_o && |req_error_o));
  // The start pulse is registered out of ARB_GRANT, so it trails that state by one cycle.
  a_start:    assert property (@(posedge PCLK_i) disable iff (!PRESETn_i)
                               eng_start_o |-> $past(state_q) == ARB_GRANT);

endmodule

// File: tb/tb_sdcard_dma_arbiter.sv
// tb/tb_sdcard_dma_arbiter.sv - randomized self-checking bench for sdcard_dma_arbiter
module tb_sdcard_dma_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int LW = 16;
  localparam int TO = 32;
  localparam int IW = $clog2(NR);
  localparam int M_DONE = 0, M_ERR = 1, M_BOTH = 2, M_SILENT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arb_enable_i, security_lock_i, access_granted_i;
  logic [1:0]        power_state_i;
  logic [NR-1:0]     req_valid_i, req_we_i;
  logic [NR*AW-1:0]  req_addr_i;
  logic [NR*LW-1:0]  req_len_i;
  logic [NR-1:0]     req_ready_o, req_done_o, req_error_o;
  logic              eng_start_o, eng_we_o, eng_done_i, eng_error_i;
  logic [AW-1:0]     eng_addr_o;
  logic [LW-1:0]     eng_len_o;
  logic [IW-1:0]     grant_id_o;
  logic              arb_busy_o, timeout_o;

  always #5 clk = ~clk;

  sdcard_dma_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK_i(clk), .PRESETn_i(rst_n),
    .arb_enable_i(arb_enable_i), .security_lock_i(security_lock_i),
    .access_granted_i(access_granted_i), .power_state_i(power_state_i),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
    .req_we_i(req_we_i), .req_ready_o(req_ready_o), .req_done_o(req_done_o),
    .req_error_o(req_error_o), .eng_start_o(eng_start_o), .eng_addr_o(eng_addr_o),
    .eng_len_o(eng_len_o), .eng_we_o(eng_we_o), .eng_done_i(eng_done_i),
    .eng_error_i(eng_error_i), .grant_id_o(grant_id_o), .arb_busy_o(arb_busy_o),
    .timeout_o(timeout_o)
  );

  int n_vec = 0;
  int n_bad = 0;
  int rr_last = NR - 1;
  logic [AW-1:0] d_addr [NR];
  logic [LW-1:0] d_len  [NR];
  logic          d_we   [NR];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int last);
    for (int k = 1; k <= NR; k++) begin
      int c = (last + k) % NR;
      if (((v >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  function automatic logic [NR-1:0] oh(input int id);
    logic [NR-1:0] one = 1;
    return one << id;
  endfunction

  task automatic load_desc();
    for (int i = 0; i < NR; i++) begin
      req_addr_i[i*AW +: AW] = d_addr[i];
      req_len_i[i*LW +: LW]  = d_len[i];
      req_we_i[i]            = d_we[i];
    end
  endtask

  task automatic open_gate();
    arb_enable_i = 1'b1; security_lock_i = 1'b0; access_granted_i = 1'b1; power_state_i = 2'b00;
  endtask

  // Entered at a negedge with the arbiter idle and the gate open; returns at a negedge in idle.
  task automatic xfer(input logic [NR-1:0] vld, input int mode, input int dly, input bit chaos);
    int exp_id, fin;
    logic quiet_bad;
    exp_id = pick(vld, rr_last);
    load_desc();
    req_valid_i = vld;
    @(negedge clk);
    chk("ready", req_ready_o, oh(exp_id));
    chk("grant_id", grant_id_o, exp_id);
    chk("busy_grant", arb_busy_o, 1);
    rr_last = exp_id;
    req_valid_i = '0;
    @(negedge clk);
    if (d_len[exp_id] == 0) begin
      chk("zl_error", req_error_o, oh(exp_id));
      chk("zl_nostart", eng_start_o, 0);
      chk("zl_done", req_done_o, 0);
    end else begin
      chk("start", eng_start_o, 1);
      chk("eng_addr", eng_addr_o, d_addr[exp_id]);
      chk("eng_len", eng_len_o, d_len[exp_id]);
      chk("eng_we", eng_we_o, d_we[exp_id]);
      fin = (mode == M_SILENT) ? TO : dly + 1;
      quiet_bad = 1'b0;
      for (int c = 0; c < fin; c++) begin
        if (mode != M_SILENT && c == dly) begin
          eng_done_i  = (mode == M_DONE || mode == M_BOTH);
          eng_error_i = (mode == M_ERR || mode == M_BOTH);
        end
        if (chaos) begin
          security_lock_i = $urandom_range(1); arb_enable_i = $urandom_range(1);
          access_granted_i = $urandom_range(1); power_state_i = 2'($urandom_range(3));
        end
        @(negedge clk);
        eng_done_i = 1'b0; eng_error_i = 1'b0;
        if (c + 1 < fin && (|req_done_o || |req_error_o || timeout_o || eng_start_o))
          quiet_bad = 1'b1;
      end
      chk("wait_quiet", quiet_bad, 0);
      chk("done", req_done_o, (mode == M_DONE) ? oh(exp_id) : '0);
      chk("error", req_error_o, (mode == M_DONE) ? '0 : oh(exp_id));
      chk("timeout", timeout_o, mode == M_SILENT);
      chk("grant_id_end", grant_id_o, exp_id);
    end
    chk("busy_release", arb_busy_o, 1);
    open_gate();
    @(negedge clk);
    chk("busy_idle", arb_busy_o, 0);
  endtask

  task automatic blocked(input logic [NR-1:0] vld, input int how, input int n);
    case (how)
      0: arb_enable_i = 1'b0;
      1: security_lock_i = 1'b1;
      2: access_granted_i = 1'b0;
      default: power_state_i = 2'($urandom_range(3, 1));
    endcase
    load_desc();
    req_valid_i = vld;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("blocked_ready", req_ready_o, 0);
      chk("blocked_busy", arb_busy_o, 0);
    end
    req_valid_i = '0;
    open_gate();
  endtask

  initial begin
    logic [NR-1:0] v;
    int m;
    open_gate();
    req_valid_i = '0; eng_done_i = 1'b0; eng_error_i = 1'b0;
    for (int i = 0; i < NR; i++) begin
      d_addr[i] = $urandom; d_len[i] = LW'($urandom_range(200, 1)); d_we[i] = 1'($urandom_range(1));
    end
    load_desc();
    repeat (3) @(negedge clk);
    chk("rst_busy", arb_busy_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_start", eng_start_o, 0);
    chk("rst_addr", eng_addr_o, 0);
    chk("rst_grant", grant_id_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) xfer('1, M_DONE, 5, 1'b0);

    d_addr[1] = 32'h2000_0100; d_len[1] = 16; d_we[1] = 1'b1;
    xfer(3'b010, M_DONE, 20, 1'b0);

    d_len[2] = 0;
    xfer(3'b100, M_DONE, 0, 1'b0);
    d_len[2] = 7;

    xfer(3'b001, M_SILENT, 0, 1'b0);
    xfer(3'b001, M_DONE, TO - 1, 1'b0);
    blocked(3'b011, 1, 4);
    xfer(3'b011, M_DONE, 10, 1'b1);
    blocked(3'b100, 3, 4);
    xfer(3'b100, M_BOTH, 2, 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NR; i++) begin
        d_addr[i] = $urandom; d_we[i] = 1'($urandom_range(1));
        d_len[i] = ($urandom_range(5) == 0) ? '0 : LW'($urandom);
      end
      v = NR'($urandom_range((1 << NR) - 1, 1));
      m = $urandom_range(3);
      if ($urandom_range(3) == 0) blocked(v, $urandom_range(3), $urandom_range(3, 1));
      if ($urandom_range(3) == 0) begin
        eng_done_i = 1'b1; eng_error_i = 1'($urandom_range(1));
        @(negedge clk);
        eng_done_i = 1'b0; eng_error_i = 1'b0;
        @(negedge clk);
        chk("stray_done", req_done_o, 0);
        chk("stray_error", req_error_o, 0);
      end
      xfer(v, m, $urandom_range(TO - 1), 1'($urandom_range(1)));
    end

    d_len[2] = 9;
    load_desc();
    req_valid_i = 3'b100;
    @(negedge clk);
    chk("pre_rst_ready", req_ready_o, oh(pick(3'b100, rr_last)));
    req_valid_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", arb_busy_o, 0);
    chk("arst_addr", eng_addr_o, 0);
    chk("arst_len", eng_len_o, 0);
    chk("arst_grant", grant_id_o, 0);
    eng_done_i = 1'b1;
    @(negedge clk);
    eng_done_i = 1'b0;
    chk("arst_done", req_done_o, 0);
    rst_n = 1'b1;
    rr_last = NR - 1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) d_len[i] = 4;
    xfer('1, M_DONE, 3, 1'b0);
    chk("post_rst_first", rr_last, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
